reaction_timer: RTL and testbench

- Sits directly downstream of the F1 start-light top. Consumes its 8-bit `data_out` light pattern plus a raw player button.
- Measures the player's reaction time, in milliseconds, from lights-out to button press.
- Detects false starts (press before lights-out) and timeouts.
- Keeps a running best (minimum) valid time for display.

---
 rtl/reaction_timer.sv | 175 +++++++++++++++++
 tb/tb_reaction_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction timer fed by the start-light sequencer. It measures the time in milliseconds
// from lights-out to the player's button press, flags false starts and timeouts, and keeps the best time.
module reaction_timer #(
    parameter int CLK_PER_MS = 1000,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           lights,
    input  logic                 button,
    output logic [CNT_WIDTH-1:0] react_ms,
    output logic                 valid,
    output logic                 foul,
    output logic                 timeout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] best_ms,
    output logic                 new_best
);

    localparam int                   PRE_W   = $clog2(CLK_PER_MS);
    localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(CLK_PER_MS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_FOUL   = 3'd4
    } state_t;

    state_t               state_r, next_state_s;
    logic                 sync1_r, sync2_r, sync3_r, press_r;
    logic [PRE_W-1:0]     pre_r;
    logic [CNT_WIDTH-1:0] ms_r;
    logic [CNT_WIDTH-1:0] react_ms_r, best_ms_r;
    logic                 valid_r, new_best_r, foul_r, timeout_r, busy_r;
    logic                 lights_off_s, lights_full_s, pre_wrap_s, saturate_s;

    assign lights_off_s  = (lights == 8'h00);
    assign lights_full_s = (lights == 8'hFF);
    assign pre_wrap_s    = (pre_r == PRE_MAX);
    assign saturate_s    = pre_wrap_s && (ms_r == CNT_MAX);

    // Button synchroniser and rising-edge detector; press is registered, so a held button yields one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            press_r <= sync2_r & ~sync3_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a press always outranks the concurrent lights or saturation event.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_r && !lights_off_s) begin
                    next_state_s = ST_FOUL;
                end else if (lights_full_s) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (press_r) begin
                    next_state_s = ST_FOUL;
                end else if (lights_off_s) begin
                    next_state_s = ST_TIMING;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_TIMING: begin
                if (press_r || saturate_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_TIMING;
                end
            end
            ST_DONE: begin
                if (!lights_off_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_FOUL: begin
                if (lights_off_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FOUL;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Prescaler, ms counter, result and best-time registers, and the registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r      <= {PRE_W{1'b0}};
            ms_r       <= {CNT_WIDTH{1'b0}};
            react_ms_r <= {CNT_WIDTH{1'b0}};
            best_ms_r  <= {CNT_WIDTH{1'b1}};
            valid_r    <= 1'b0;
            new_best_r <= 1'b0;
            foul_r     <= 1'b0;
            timeout_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            valid_r    <= 1'b0;
            new_best_r <= 1'b0;
            foul_r     <= (next_state_s == ST_FOUL);
            busy_r     <= (next_state_s == ST_TIMING);
            case (state_r)
                ST_ARMED: begin
                    if (next_state_s == ST_TIMING) begin
                        pre_r     <= {PRE_W{1'b0}};
                        ms_r      <= {CNT_WIDTH{1'b0}};
                        timeout_r <= 1'b0;
                    end
                end
                ST_TIMING: begin
                    if (press_r) begin
                        react_ms_r <= ms_r;
                        valid_r    <= 1'b1;
                        if (ms_r < best_ms_r) begin
                            best_ms_r  <= ms_r;
                            new_best_r <= 1'b1;
                        end
                    end else if (saturate_s) begin
                        react_ms_r <= CNT_MAX;
                        timeout_r  <= 1'b1;
                        valid_r    <= 1'b1;
                    end else if (pre_wrap_s) begin
                        pre_r <= {PRE_W{1'b0}};
                        ms_r  <= ms_r + CNT_WIDTH'(1'b1);
                    end else begin
                        pre_r <= pre_r + PRE_W'(1'b1);
                    end
                end
                default: begin
                    pre_r <= pre_r;
                end
            endcase
        end
    end

    assign react_ms = react_ms_r;
    assign valid    = valid_r;
    assign foul     = foul_r;
    assign timeout  = timeout_r;
    assign busy     = busy_r;
    assign best_ms  = best_ms_r;
    assign new_best = new_best_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: an 8-bit instance (CLK_PER_MS=4) covers the main runs, and a 4-bit instance covers the timeout.
module tb_reaction_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lights;
    logic       button;
    logic       use_b;

    logic [7:0] lights_a, lights_b;
    logic       button_a, button_b;
    logic [7:0] react_a, best_a;
    logic       valid_a, foul_a, timeout_a, busy_a, new_best_a;
    logic [3:0] react_b, best_b;
    logic       valid_b, foul_b, timeout_b, busy_b, new_best_b;

    int errors = 0;
    int checks = 0;
    int valid_cnt_a = 0;
    int v0;

    logic [7:0] cap_react, cap_best;
    logic       cap_new_best, cap_timeout;
    int         cap_cycles;
    logic       got;

    logic [7:0] sel_react, sel_best;
    logic       sel_valid, sel_new_best, sel_timeout;

    always #5 clk = ~clk;

    assign lights_a = use_b ? 8'h00 : lights;
    assign button_a = use_b ? 1'b0 : button;
    assign lights_b = use_b ? lights : 8'h00;
    assign button_b = use_b ? button : 1'b0;

    assign sel_react    = use_b ? {4'h0, react_b} : react_a;
    assign sel_best     = use_b ? {4'h0, best_b} : best_a;
    assign sel_valid    = use_b ? valid_b : valid_a;
    assign sel_new_best = use_b ? new_best_b : new_best_a;
    assign sel_timeout  = use_b ? timeout_b : timeout_a;

    reaction_timer #(.CLK_PER_MS(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .lights(lights_a), .button(button_a),
        .react_ms(react_a), .valid(valid_a), .foul(foul_a), .timeout(timeout_a),
        .busy(busy_a), .best_ms(best_a), .new_best(new_best_a)
    );

    reaction_timer #(.CLK_PER_MS(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .lights(lights_b), .button(button_b),
        .react_ms(react_b), .valid(valid_b), .foul(foul_b), .timeout(timeout_b),
        .busy(busy_b), .best_ms(best_b), .new_best(new_best_b)
    );

    always @(posedge clk) begin
        if (valid_a) valid_cnt_a <= valid_cnt_a + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start-light ladder 0x01 -> 0xFF, two cycles per step; leaves the DUT in ARMED.
    task automatic ladder();
        logic [7:0] pat;
        pat = 8'h01;
        for (int i = 0; i < 8; i++) begin
            lights = pat;
            repeat (2) @(posedge clk);
            #1;
            pat = {pat[6:0], 1'b1};
        end
    endtask

    task automatic wait_result(input int budget);
        got = 1'b0;
        cap_cycles = 0;
        for (int i = 1; i <= budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (sel_valid) begin
                got          = 1'b1;
                cap_cycles   = i;
                cap_react    = sel_react;
                cap_best     = sel_best;
                cap_new_best = sel_new_best;
                cap_timeout  = sel_timeout;
            end
        end
        check_eq("result_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("valid_one_cycle", {31'd0, sel_valid}, 32'd0);
    endtask

    // Full sequence: button raised `delay` clock edges after lights-out.
    task automatic run_seq(input int delay);
        ladder();
        lights = 8'h00;
        repeat (delay) @(posedge clk);
        #1 button = 1'b1;
        wait_result(400);
        repeat (2) @(posedge clk);
        #1 button = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; lights = 8'h00; button = 1'b0; use_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_react", react_a, 8'h00);
        check_eq("rst_best", best_a, 8'hFF);
        check_eq("rst_flags", {valid_a, foul_a, timeout_a, busy_a, new_best_a}, 5'b0);
        check_eq("rst_best_b", best_b, 4'hF);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Press lands 42 TIMING cycles in -> 10 ms
        v0 = valid_cnt_a;
        run_seq(40);
        check_eq("run1_react", cap_react, 8'd10);
        check_eq("run1_new_best", cap_new_best, 1'b1);
        check_eq("run1_best", cap_best, 8'd10);
        check_eq("run1_timeout", cap_timeout, 1'b0);
        check_eq("run1_valid_count", valid_cnt_a - v0, 1);

        // 62 cycles -> 15 ms, not a new best
        run_seq(60);
        check_eq("run2_react", cap_react, 8'd15);
        check_eq("run2_best", cap_best, 8'd10);
        check_eq("run2_new_best", cap_new_best, 1'b0);

        run_seq(40);
        check_eq("run3_react", cap_react, 8'd10);
        check_eq("run3_new_best", cap_new_best, 1'b0);
        check_eq("run3_best", cap_best, 8'd10);

        // False start in IDLE while lights = 0x07
        v0 = valid_cnt_a;
        lights = 8'h01; repeat (2) @(posedge clk); #1;
        lights = 8'h03; repeat (2) @(posedge clk); #1;
        lights = 8'h07; button = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("foul_set", foul_a, 1'b1);
        check_eq("foul_busy", busy_a, 1'b0);
        check_eq("foul_react_hold", react_a, 8'd10);
        check_eq("foul_no_valid", valid_cnt_a - v0, 0);
        button = 1'b0; lights = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("foul_clear", foul_a, 1'b0);
        check_eq("foul_idle_busy", busy_a, 1'b0);

        // Press in ARMED on the same cycle lights drop to zero
        ladder();
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1 lights = 8'h00;
        @(posedge clk);
        #1;
        check_eq("armed_press_foul", foul_a, 1'b1);
        check_eq("armed_press_busy", busy_a, 1'b0);
        button = 1'b0;
        @(posedge clk);
        #1;
        check_eq("armed_foul_exit", foul_a, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("armed_no_valid", valid_cnt_a - v0, 0);

        // Button held from IDLE through lights-out produces no press
        button = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        ladder();
        lights = 8'h00;
        v0 = valid_cnt_a;
        repeat (30) @(posedge clk);
        #1;
        check_eq("held_busy", busy_a, 1'b1);
        check_eq("held_no_valid", valid_cnt_a - v0, 0);
        button = 1'b0;
        repeat (3) @(posedge clk);
        #1 button = 1'b1;
        wait_result(100);
        check_eq("held_react", cap_react, 8'd8);
        check_eq("held_new_best", cap_new_best, 1'b1);
        check_eq("held_best", cap_best, 8'd8);
        repeat (2) @(posedge clk);
        #1 button = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("held_one_result", valid_cnt_a - v0, 1);

        // Asynchronous reset between edges while timing
        ladder();
        lights = 8'h00;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_react", react_a, 8'h00);
        check_eq("arst_best", best_a, 8'hFF);
        check_eq("arst_flags", {valid_a, foul_a, timeout_a, busy_a, new_best_a}, 5'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_seq(40);
        check_eq("arst_run_react", cap_react, 8'd10);
        check_eq("arst_run_best", cap_best, 8'd10);
        check_eq("arst_run_new_best", cap_new_best, 1'b1);

        // Timeout on the 4-bit instance: saturates after 16*4 TIMING cycles
        use_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ladder();
        lights = 8'h00;
        wait_result(100);
        check_eq("tmo_cycles", cap_cycles, 65);
        check_eq("tmo_react", cap_react, 8'd15);
        check_eq("tmo_flag", cap_timeout, 1'b1);
        check_eq("tmo_best", cap_best, 8'd15);
        check_eq("tmo_new_best", cap_new_best, 1'b0);
        ladder();
        check_eq("tmo_hold_armed", timeout_b, 1'b1);
        lights = 8'h00;
        @(posedge clk);
        #1;
        check_eq("tmo_clear_entry", timeout_b, 1'b0);
        check_eq("tmo_busy_entry", busy_b, 1'b1);
        repeat (9) @(posedge clk);
        #1 button = 1'b1;
        wait_result(100);
        check_eq("b_react", cap_react, 8'd3);
        check_eq("b_best", cap_best, 8'd3);
        check_eq("b_new_best", cap_new_best, 1'b1);
        check_eq("b_timeout", cap_timeout, 1'b0);
        button = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
